// File: rtl/nes_controller_reader_if.sv
// Pad-side serial pins plus the registered button word and status seen by the CPU.
// master = reader (drives latch/clk/buttons), slave = controller model / consumer side.
interface nes_controller_reader_if;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic       frame_valid;
  logic       busy;

  modport master (
    input  nes_data,
    output nes_latch,
    output nes_clk,
    output buttons,
    output frame_valid,
    output busy
  );

  modport slave (
    output nes_data,
    input  nes_latch,
    input  nes_clk,
    input  buttons,
    input  frame_valid,
    input  busy
  );
endinterface

// File: rtl/nes_controller_reader.sv
// NES pad reader: latch, clock out 8 active-low bits, publish an active-high button word.
// Frame = 16*CLK_DIV+9 cycles every POLL_PERIOD; no backpressure. Option: NES_DEBOUNCE_EN.
module nes_controller_reader #(
  parameter int CLK_DIV     = 300,
  parameter int POLL_PERIOD = 833333
) (
  input logic                    clk,
  input logic                    reset,
  nes_controller_reader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    SAMPLE = 3'd2,
    CLK_HI = 3'd3,
    CLK_LO = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int POLL_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int DIV_W  = $clog2(2 * CLK_DIV);

  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_PERIOD - 1);
  localparam logic [DIV_W-1:0]  LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  HALF_LAST  = DIV_W'(CLK_DIV - 1);

  state_t            state;
  state_t            state_next;
  logic              sync_q1;
  logic              sync_q2;
  logic [POLL_W-1:0] poll_cnt;
  logic              poll_tick;
  logic [DIV_W-1:0]  div_cnt;
  logic              div_last;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic [7:0]        buttons_q;
  logic [7:0]        buttons_d;
  logic              latch_q;
  logic              latch_d;
  logic              nclk_q;
  logic              nclk_d;
  logic              fv_q;
  logic              fv_d;
  logic              busy_q;
  logic              busy_d;
`ifdef NES_DEBOUNCE_EN
  logic [7:0]        prev_raw;
`endif

  assign poll_tick = (poll_cnt == POLL_LAST);

  always_comb begin
    div_last = 1'b0;
    case (state)
      LATCH:          div_last = (div_cnt == LATCH_LAST);
      CLK_HI, CLK_LO: div_last = (div_cnt == HALF_LAST);
      default:        div_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (poll_tick) state_next = LATCH;
      LATCH:   if (div_last)  state_next = SAMPLE;
      SAMPLE:  state_next = (bit_idx == 3'd7) ? DONE : CLK_HI;
      CLK_HI:  if (div_last)  state_next = CLK_LO;
      CLK_LO:  if (div_last)  state_next = SAMPLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pin outputs are decoded from the next state and registered, so they line up
  // with the state they describe and never glitch at the pads.
  always_comb begin
    latch_d = (state_next == LATCH);
    nclk_d  = (state_next == CLK_HI);
    busy_d  = (state_next != IDLE);
    fv_d    = (state == DONE);
`ifdef NES_DEBOUNCE_EN
    buttons_d = ((state == DONE) && (shift == prev_raw)) ? shift : buttons_q;
`else
    buttons_d = (state == DONE) ? shift : buttons_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1   <= 1'b1;
      sync_q2   <= 1'b1;
      poll_cnt  <= '0;
      div_cnt   <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      buttons_q <= 8'h00;
      latch_q   <= 1'b0;
      nclk_q    <= 1'b0;
      fv_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q1   <= bus.nes_data;
      sync_q2   <= sync_q1;
      poll_cnt  <= poll_tick ? '0 : poll_cnt + POLL_W'(1);
      div_cnt   <= (state_next != state) ? '0 : div_cnt + DIV_W'(1);
      buttons_q <= buttons_d;
      latch_q   <= latch_d;
      nclk_q    <= nclk_d;
      fv_q      <= fv_d;
      busy_q    <= busy_d;
      if (state == LATCH) begin
        bit_idx <= 3'd0;
      end else if ((state == CLK_LO) && div_last) begin
        bit_idx <= bit_idx + 3'd1;
      end
      // Pad data is active-low; store pressed as 1.
      if (state == SAMPLE) begin
        shift[bit_idx] <= ~sync_q2;
      end
    end
  end

`ifdef NES_DEBOUNCE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_raw <= 8'h00;
    end else if (state == DONE) begin
      prev_raw <= shift;
    end
  end
`endif

  assign bus.nes_latch   = latch_q;
  assign bus.nes_clk     = nclk_q;
  assign bus.buttons     = buttons_q;
  assign bus.frame_valid = fv_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_nes_controller_reader.sv
// Directed bench for nes_controller_reader with a 4021-style pad model (CLK_DIV=2, POLL_PERIOD=64).
module tb_nes_controller_reader;

`ifdef NES_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  logic [7:0] pad;
  logic [7:0] sr = 8'hFF;

  nes_controller_reader_if bus ();

  nes_controller_reader #(.CLK_DIV(2), .POLL_PERIOD(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4021: parallel load while latch is high, shift toward Q8 on clock rise.
  always @(posedge bus.nes_latch or posedge bus.nes_clk) begin
    if (bus.nes_latch) sr <= ~pad;
    else               sr <= {1'b1, sr[7:1]};
  end
  assign bus.nes_data = sr[0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for nes_latch to rise; buttons must hold and no strobe may appear meanwhile.
  task automatic wait_latch(input string tag, input int exp_n);
    int         n;
    int         chg;
    int         fvs;
    logic [7:0] b0;
    b0  = bus.buttons;
    n   = 0;
    chg = 0;
    fvs = 0;
    while (!bus.nes_latch && n < 200) begin
      tick();
      n++;
      if (bus.buttons !== b0) chg++;
      if (bus.frame_valid) fvs++;
    end
    chk({tag, "_gap"}, n, exp_n);
    chk({tag, "_hold"}, chg, 0);
    chk({tag, "_nofv"}, fvs, 0);
  endtask

  // Entered at the first sample with nes_latch high; runs to the frame_valid sample.
  task automatic run_frame(input string tag, input logic [7:0] exp_btn);
    int   lat;
    int   bsy;
    int   pulses;
    int   bad_hi;
    int   hi_run;
    int   fvs;
    logic prev_clk;
    lat = 1; bsy = 1; pulses = 0; bad_hi = 0; hi_run = 0; fvs = 0; prev_clk = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.nes_latch) lat++;
      if (bus.nes_clk) begin
        if (!prev_clk) pulses++;
        hi_run++;
      end else begin
        if (prev_clk && hi_run != 2) bad_hi++;
        hi_run = 0;
      end
      if (bus.frame_valid) fvs++;
      prev_clk = bus.nes_clk;
      if (!bus.busy) break;
      bsy++;
    end
    chk({tag, "_latch_len"}, lat, 4);
    chk({tag, "_busy_len"}, bsy, 41);
    chk({tag, "_pulses"}, pulses, 7);
    chk({tag, "_clk_hi_len"}, bad_hi, 0);
    chk({tag, "_fv_count"}, fvs, 1);
    chk({tag, "_fv"}, bus.frame_valid, 1);
    chk({tag, "_buttons"}, bus.buttons, exp_btn);
    tick();
    chk({tag, "_fv_drop"}, bus.frame_valid, 0);
    chk({tag, "_buttons_hold"}, bus.buttons, exp_btn);
  endtask

  initial begin
    int pulses;
    logic prev_clk;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    pad   = 8'h09;

    repeat (3) tick();
    chk("rst_latch", bus.nes_latch, 0);
    chk("rst_clk", bus.nes_clk, 0);
    chk("rst_buttons", bus.buttons, 8'h00);
    chk("rst_fv", bus.frame_valid, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;

    // A+Start pressed; debounce needs a second identical frame.
    wait_latch("w0", 64);
    run_frame("a_start_1", DEB ? 8'h00 : 8'h09);
    wait_latch("w1", 22);
    run_frame("a_start_2", 8'h09);

    pad = 8'h00;
    wait_latch("w2", 22);
    run_frame("none_1", DEB ? 8'h09 : 8'h00);
    wait_latch("w3", 22);
    run_frame("none_2", 8'h00);

    pad = 8'hFF;
    wait_latch("w4", 22);
    run_frame("all_1", DEB ? 8'h00 : 8'hFF);
    wait_latch("w5", 22);
    run_frame("all_2", 8'hFF);

    // Reset for one cycle during the nes_clk high phase that follows bit 3.
    wait_latch("w6", 22);
    pulses   = 0;
    prev_clk = 1'b0;
    for (int i = 0; i < 100 && pulses < 4; i++) begin
      tick();
      if (bus.nes_clk && !prev_clk) pulses++;
      prev_clk = bus.nes_clk;
    end
    chk("mid_reached_bit3", pulses, 4);
    reset = 1'b1;
    tick();
    chk("mid_latch", bus.nes_latch, 0);
    chk("mid_clk", bus.nes_clk, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_buttons", bus.buttons, 8'h00);
    chk("mid_fv", bus.frame_valid, 0);
    reset = 1'b0;

    pad = 8'h09;
    wait_latch("w7", 64);
    run_frame("post_rst_1", DEB ? 8'h00 : 8'h09);
    wait_latch("w8", 22);
    run_frame("post_rst_2", 8'h09);

    pad = 8'h81;
    wait_latch("w9", 22);
    run_frame("chg_1", DEB ? 8'h09 : 8'h81);
    wait_latch("w10", 22);
    run_frame("chg_2", 8'h81);

    // Single-frame glitch to all-pressed.
    pad = 8'hFF;
    wait_latch("w11", 22);
    run_frame("glitch", DEB ? 8'h81 : 8'hFF);
    pad = 8'h81;
    wait_latch("w12", 22);
    run_frame("after_glitch", 8'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nes_controller_reader.md
Name: nes_controller_reader

Overview:
- Serial front end for the NES gamepad; it is the stage directly upstream of the CPU's 8-bit GIO_pins input.
- It periodically latches the controller, clocks out the 8 button bits and converts them from active-low to active-high.
- It holds the result in a registered 8-bit button word that drives GIO_pins.
- It also publishes a one-cycle frame-valid strobe and a busy flag for debug and for future interrupt use.

Parameters:
- CLK_DIV, 300: clk cycles per half nes_clk period (6 us at 50 MHz). Must be ≥ 2.
- POLL_PERIOD, 833333: clk cycles between frame starts (60 Hz at 50 MHz). Must be > 16*CLK_DIV+9.

Ports:
- clk  input  1: system clock, same clock as the CPU.
- reset  input  1: synchronous, active-high reset.
- nes_data  input  1: serial data from the controller, active-low (0 = pressed). Asynchronous to clk.
- nes_latch  output  1: latch strobe to the controller.
- nes_clk  output  1: shift clock to the controller.
- buttons  output  8: registered button state, active-high. Bit order: [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right. Connects to CPU GIO_pins.
- frame_valid  output  1: one-cycle pulse in the cycle buttons updates.
- busy  output  1: high while a frame is in progress (any state except IDLE).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, poll_cnt=0, bit_idx=0, shift=0, buttons=8'h00, nes_latch=0, nes_clk=0, frame_valid=0, busy=0.
- Input synchroniser: nes_data passes through a 2-flop synchroniser, reset to 1 (released). All sampling uses the synchronised value.
- Poll counter: poll_cnt is free-running, counts 0..POLL_PERIOD-1 and wraps. The tick is the cycle in which poll_cnt==POLL_PERIOD-1.
  - If the tick occurs in IDLE, state becomes LATCH on the next edge.
  - A tick outside IDLE is dropped; no queuing.
- State machine: IDLE → LATCH → SAMPLE → {CLK_HI → CLK_LO → SAMPLE}×7 → DONE → IDLE.
  - LATCH: nes_latch=1 for exactly 2*CLK_DIV cycles. bit_idx=0.
  - SAMPLE: lasts 1 cycle, with nes_latch=0 and nes_clk=0.
    - shift[bit_idx] <= ~nes_data_sync.
    - If bit_idx==7, go to DONE; otherwise go to CLK_HI.
  - CLK_HI: nes_clk=1 for CLK_DIV cycles.
  - CLK_LO: nes_clk=0 for CLK_DIV cycles. On exit, bit_idx increments.
    - The CLK_LO length (≥2) absorbs the synchroniser latency.
  - DONE: lasts 1 cycle.
    - buttons <= shift, or the debounce result (see Optional Feature).
    - frame_valid=1 in the cycle after the DONE edge, i.e. aligned with the new buttons value. Then return to IDLE.
- Frame timing: a frame spans 16*CLK_DIV+9 cycles from LATCH entry to IDLE return.
- Pulse count: exactly 7 nes_clk rising edges per frame. No nes_clk pulse after bit 7.
- Stable outputs:
  - buttons changes only at DONE and holds between frames.
  - All outputs are registered; no glitching combinational paths to pads.
- Reset mid-frame:
  - Next edge: nes_latch=0, nes_clk=0, busy=0, buttons=0, no frame_valid.
  - poll_cnt restarts from 0, so the next LATCH starts POLL_PERIOD cycles after reset deasserts.
- reset held: all outputs stay at reset values. poll_cnt holds at 0.

Optional Feature:
- Macro: NES_DEBOUNCE_EN.
- Defined:
  - The previous frame's raw shift word is kept in prev_raw (reset 0).
  - At DONE, buttons <= shift only if shift==prev_raw; otherwise buttons holds. prev_raw <= shift always.
  - frame_valid still pulses every frame.
  - A change therefore appears after two consecutive identical frames.
- Undefined: buttons <= shift every frame, and prev_raw logic is absent.

Test Plan (CLK_DIV=2, POLL_PERIOD=64; the bench models a 4021 shift register, active-low, shifting on nes_clk rise):
- Reset release at cycle 0 → all outputs 0. nes_latch rises at cycle 64 and is high exactly 4 cycles. busy=1 for 41 cycles.
- Pad holds A+Start pressed → exactly 7 nes_clk pulses, each 2 cycles high. buttons=8'h09 with a single-cycle frame_valid. buttons is stable until the next frame.
- nes_data held 1 (nothing pressed) → buttons=8'h00 every frame. nes_data held 0 → buttons=8'hFF.
- reset asserted one cycle during the CLK_HI of bit 3 → nes_latch=nes_clk=0 and buttons=0 on the next edge. No frame_valid. Next latch comes 64 cycles after reset deasserts.
- Pad changes 8'h09→8'h81 between frames:
  - Without NES_DEBOUNCE_EN → 8'h81 at the very next frame.
  - With NES_DEBOUNCE_EN → 8'h09 holds one frame, then 8'h81. A single-frame glitch of 8'hFF never reaches buttons.
